// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares one uart_tx between N_REQ byte producers. Each producer has a
//   one-byte holding register. Grants go round-robin. Grants are paced at
//   least one UART frame apart because uart_tx has no busy output.
//
//   Optional feature: define UART_SCHED_PRIO_EN to give requester 0 strict
//   priority. Requesters 1..N_REQ-1 then share round-robin among themselves.
//   With the macro undefined, all N_REQ requesters are pure round-robin.
//
// Ports
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   asynchronous active-high reset
//   req_flag  in   [N_REQ]   per-requester one-cycle byte strobe
//   req_data  in   [8*N_REQ] byte i on bits [8i+7:8i]
//   req_ovf   out  [N_REQ]   one-cycle pulse when requester i's byte is dropped
//   po_data   out  [8]       byte to uart_tx pi_data
//   po_flag   out            one-cycle strobe to uart_tx pi_falg
//   busy      out            WAIT state or any holding register valid
//
// state | meaning
// IDLE  | no frame being paced; grant the next pending holding register
// WAIT  | frame in flight; cnt counts FRAME_CYC cycles before the next grant

module uart_tx_sched #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FRAME_BITS = 10,
    parameter int N_REQ      = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_REQ-1:0]     req_flag,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ovf,
    output logic [7:0]           po_data,
    output logic                 po_flag,
    output logic                 busy
);

    localparam int BAUD_CYC  = CLK_FREQ / UART_BPS;
    localparam int FRAME_CYC = BAUD_CYC * FRAME_BITS;
    localparam int CW        = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam int LW        = $clog2(N_REQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYC - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     last_q, last_d;
    logic [N_REQ-1:0]  hv_q, hv_d;
    logic [7:0]        hold_q [N_REQ];
    logic [7:0]        hold_d [N_REQ];
    logic [7:0]        po_data_q, po_data_d;
    logic              po_flag_q, po_flag_d;
    logic [N_REQ-1:0]  req_ovf_q, req_ovf_d;

    logic              gnt_vld;
    logic [LW-1:0]     gnt_idx;
    logic              gnt_upd_last;
    logic [LW-1:0]     rr_idx;

    // Grant selection: first valid holding register after last, wrapping.
    always_comb begin
        gnt_vld      = 1'b0;
        gnt_idx      = '0;
        gnt_upd_last = 1'b0;
        rr_idx       = '0;
        if (state_q == ST_IDLE) begin
`ifdef UART_SCHED_PRIO_EN
            if (hv_q[0]) begin
                // Requester 0 bypasses the rotation and leaves last untouched.
                gnt_vld = 1'b1;
                gnt_idx = '0;
            end else begin
                // last only ever holds 1..N_REQ-1 here, so last-1 is never negative.
                for (int off = 1; off < N_REQ; off++) begin
                    rr_idx = LW'(((int'(last_q) - 1 + off) % (N_REQ - 1)) + 1);
                    if (!gnt_vld && hv_q[rr_idx]) begin
                        gnt_vld      = 1'b1;
                        gnt_idx      = rr_idx;
                        gnt_upd_last = 1'b1;
                    end
                end
            end
`else
            for (int off = 1; off <= N_REQ; off++) begin
                rr_idx = LW'((int'(last_q) + off) % N_REQ);
                if (!gnt_vld && hv_q[rr_idx]) begin
                    gnt_vld      = 1'b1;
                    gnt_idx      = rr_idx;
                    gnt_upd_last = 1'b1;
                end
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        hv_d      = hv_q;
        hold_d    = hold_q;
        po_data_d = po_data_q;
        po_flag_d = 1'b0;
        req_ovf_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d          = ST_WAIT;
                    cnt_d            = '0;
                    po_flag_d        = 1'b1;
                    po_data_d        = hold_q[gnt_idx];
                    hv_d[gnt_idx]    = 1'b0;
                    if (gnt_upd_last) begin
                        last_d = gnt_idx;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Runs after the grant so a byte arriving on its own grant cycle
        // re-arms the slot that the grant just emptied.
        for (int i = 0; i < N_REQ; i++) begin
            if (req_flag[i]) begin
                if (!hv_q[i] || (gnt_vld && (gnt_idx == LW'(i)))) begin
                    hold_d[i] = req_data[8*i +: 8];
                    hv_d[i]   = 1'b1;
                end else begin
                    req_ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= LW'(N_REQ - 1);
            hv_q      <= '0;
            hold_q    <= '{default: '0};
            po_data_q <= 8'h00;
            po_flag_q <= 1'b0;
            req_ovf_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            hv_q      <= hv_d;
            hold_q    <= hold_d;
            po_data_q <= po_data_d;
            po_flag_q <= po_flag_d;
            req_ovf_q <= req_ovf_d;
        end
    end

    assign po_data = po_data_q;
    assign po_flag = po_flag_q;
    assign req_ovf = req_ovf_q;
    assign busy    = (state_q == ST_WAIT) || (|hv_q);

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    localparam int N_REQ = 3;
    localparam int FRAME = 100;

    logic               sys_clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic [N_REQ-1:0]   req_flag = '0;
    logic [8*N_REQ-1:0] req_data = '0;
    logic [N_REQ-1:0]   req_ovf;
    logic [7:0]         po_data;
    logic               po_flag;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pulse_cyc [$];
    int pulse_dat [$];
    int ovf_cnt [N_REQ];
    int double_cnt = 0;
    logic prev_flag = 1'b0;

    uart_tx_sched #(
        .CLK_FREQ   (1000),
        .UART_BPS   (100),
        .FRAME_BITS (10),
        .N_REQ      (N_REQ)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req_flag (req_flag),
        .req_data (req_data),
        .req_ovf  (req_ovf),
        .po_data  (po_data),
        .po_flag  (po_flag),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record every strobe and overflow pulse, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (po_flag) begin
                pulse_cyc.push_back(cyc);
                pulse_dat.push_back(int'(po_data));
                if (prev_flag) double_cnt++;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ovf[i]) ovf_cnt[i]++;
            end
        end
        prev_flag = po_flag;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input int idx, input int exp_cyc, input int exp_dat);
        if (idx < pulse_cyc.size()) begin
            chk({tag, "_cyc"}, pulse_cyc[idx], exp_cyc);
            chk({tag, "_dat"}, pulse_dat[idx], exp_dat);
        end else begin
            chk({tag, "_missing"}, 0, 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Called at a negedge; holds the strobe across one rising edge.
    task automatic drive(input logic [N_REQ-1:0] f, input logic [8*N_REQ-1:0] d);
        req_flag = f;
        req_data = d;
        @(negedge sys_clk);
        req_flag = '0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        pulse_cyc.delete();
        pulse_dat.delete();
        for (int i = 0; i < N_REQ; i++) ovf_cnt[i] = 0;
        idle(2);
    endtask

    int t0;
    int ovf_sum;

    initial begin
        // Reset values
        idle(3);
        chk("rst_po_flag", int'(po_flag), 0);
        chk("rst_po_data", int'(po_data), 8'h00);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ovf", int'(req_ovf), 0);
        do_reset();

        // Single byte
        t0 = cyc;
        drive(3'b001, 24'h0000A5);
        idle(10);
        chk("single_cnt", pulse_cyc.size(), 1);
        chk_pulse("single", 0, t0 + 2, 8'hA5);
        chk("single_hold_data", int'(po_data), 8'hA5);
        idle(t0 + 101 - cyc);
        chk("single_busy_end", int'(busy), 1);
        idle(1);
        chk("single_busy_low", int'(busy), 0);

        // Simultaneous requests
        do_reset();
        t0 = cyc;
        drive(3'b111, 24'h332211);
        idle(320);
        chk("simul_cnt", pulse_cyc.size(), 3);
        chk_pulse("simul0", 0, t0 + 2, 8'h11);
        chk_pulse("simul1", 1, t0 + 103, 8'h22);
        chk_pulse("simul2", 2, t0 + 204, 8'h33);
        ovf_sum = ovf_cnt[0] + ovf_cnt[1] + ovf_cnt[2];
        chk("simul_ovf", ovf_sum, 0);
        chk("simul_idle", int'(busy), 0);

        // Overflow
        do_reset();
        t0 = cyc;
        drive(3'b001, 24'h000010);
        idle(8);
        drive(3'b010, 24'h004000);
        drive(3'b010, 24'h004100);
        chk("ovf_pulse", int'(req_ovf), 3'b010);
        idle(1);
        chk("ovf_pulse_end", int'(req_ovf), 0);
        idle(200);
        chk("ovf_count1", ovf_cnt[1], 1);
        chk("ovf_count0", ovf_cnt[0] + ovf_cnt[2], 0);
        chk("ovf_npulse", pulse_cyc.size(), 2);
        chk_pulse("ovf_first", 0, t0 + 2, 8'h10);
        chk_pulse("ovf_kept", 1, t0 + 103, 8'h40);

        // Capture on grant
        do_reset();
        t0 = cyc;
        drive(3'b100, 24'h660000);
        drive(3'b100, 24'h770000);
        idle(220);
        chk("cap_npulse", pulse_cyc.size(), 2);
        chk_pulse("cap_old", 0, t0 + 2, 8'h66);
        chk_pulse("cap_new", 1, t0 + 103, 8'h77);
        chk("cap_ovf", ovf_cnt[0] + ovf_cnt[1] + ovf_cnt[2], 0);

        // Priority / round-robin after requester 0's grant
        do_reset();
        t0 = cyc;
        drive(3'b001, 24'h000055);
        idle(8);
        drive(3'b010, 24'h003100);
        idle(9);
        drive(3'b001, 24'h0000EE);
        idle(310);
        chk("prio_npulse", pulse_cyc.size(), 3);
        chk_pulse("prio0", 0, t0 + 2, 8'h55);
`ifdef UART_SCHED_PRIO_EN
        chk_pulse("prio1", 1, t0 + 103, 8'hEE);
        chk_pulse("prio2", 2, t0 + 204, 8'h31);
`else
        chk_pulse("prio1", 1, t0 + 103, 8'h31);
        chk_pulse("prio2", 2, t0 + 204, 8'hEE);
`endif

        // Reset mid-WAIT with two bytes pending
        do_reset();
        t0 = cyc;
        drive(3'b001, 24'h000001);
        idle(3);
        drive(3'b110, 24'h332200);
        idle(t0 + 52 - cyc);
        chk("midrst_busy_before", int'(busy), 1);
        sys_rst = 1'b1;
        #1;
        chk("midrst_po_flag", int'(po_flag), 0);
        chk("midrst_po_data", int'(po_data), 8'h00);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ovf", int'(req_ovf), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        idle(300);
        chk("midrst_npulse", pulse_cyc.size(), 1);
        chk("midrst_data_hold", int'(po_data), 8'h00);
        chk("midrst_busy_after", int'(busy), 0);

        chk("no_double_flag", double_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares the single `uart_tx` instance between several byte producers (summing controller, echo path, status reporter) in the serial-summing design. Each producer drops a byte with a one-cycle flag. The block holds one byte per producer and grants the transmitter round-robin. Because `uart_tx` has no busy output, the block paces its one-cycle `po_flag` pulses at least one UART frame apart.

## Interface

**Parameters**
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `UART_BPS`, default 9600: baud rate. Must match the `uart_tx` instance.
- `FRAME_BITS`, default 10: bits per frame (start + 8 data + stop).
- `N_REQ`, default 3: number of requesters. Legal range 2..8.
- Derived `BAUD_CYC = CLK_FREQ/UART_BPS` (integer divide).
- Derived `FRAME_CYC = BAUD_CYC*FRAME_BITS`.

**Ports**
- `sys_clk` input, 1: system clock; all logic on the rising edge.
- `sys_rst` input, 1: reset, asynchronous, active-high.
- `req_flag` input, N_REQ: per-requester one-cycle byte strobe.
- `req_data` input, 8*N_REQ: byte i on bits [8i+7:8i], valid with `req_flag[i]`.
- `req_ovf` output, N_REQ: one-cycle pulse when requester i's byte is dropped.
- `po_data` output, 8: byte to `uart_tx` `pi_data`.
- `po_flag` output, 1: one-cycle strobe to `uart_tx` `pi_falg`.
- `busy` output, 1: high when in WAIT or any holding register is valid.

## Operation

- **Holding registers:** one 8-bit `hold[i]` plus `hv[i]` per requester.
  - `req_flag[i]` with `hv[i]=0`: capture the byte and set `hv[i]`.
  - `req_flag[i]` with `hv[i]=1`, and i not granted this cycle: drop the new byte, keep the old one, and pulse `req_ovf[i]` on the next cycle.
  - `req_flag[i]` in the same cycle that i is granted: the old byte is sent, the new byte is captured, `hv[i]` stays 1, and there is no overflow.
- **FSM states:** IDLE, WAIT.
  - IDLE → WAIT when any `hv` is set.
    - Pick the first set `hv[j]`, searching from `last+1` upward and wrapping modulo N_REQ.
    - Register `po_data<=hold[j]` and `po_flag<=1`, clear `hv[j]` (subject to the capture rule above), set `last<=j`, and set `cnt<=0`.
  - WAIT: `cnt` increments each cycle. When `cnt==FRAME_CYC-1`, go to IDLE.
  - `cnt` width is `$clog2(FRAME_CYC)`; it never wraps.
- `po_data` holds its last value until the next grant.
- **Reset values:** state IDLE, all `hv` 0, `po_flag` 0, `po_data` 8'h00, `req_ovf` 0, `cnt` 0, `last` N_REQ-1 (so requester 0 wins first), `busy` 0.
- **Reset mid-WAIT:** pending bytes are discarded. A frame already started inside `uart_tx` is not the scheduler's concern.

## Timing

- `req_flag[i]` sampled at edge k sets `hv[i]`. If in IDLE, `po_flag` is high for the cycle after edge k+1. Latency is 2 cycles.
- Consecutive `po_flag` pulses are spaced exactly FRAME_CYC+1 cycles apart when requests are back-to-back.
- `po_flag` is never high for two consecutive cycles.
- `req_ovf[i]` asserts in the cycle after the offending `req_flag[i]`.
- `busy` is combinational from state and `hv`.

## Configuration

- `UART_SCHED_PRIO_EN` defined:
  - Requester 0 has strict priority: if `hv[0]` is set in IDLE it is granted, regardless of `last`.
  - Requesters 1..N_REQ-1 are round-robin among themselves; `last` is updated only by their grants.
- `UART_SCHED_PRIO_EN` undefined: pure round-robin over all N_REQ requesters.

## Test plan

Bench parameters: CLK_FREQ=1000, UART_BPS=100, N_REQ=3, which gives FRAME_CYC=100.

- **Single byte:** reset released, then `req_flag=3'b001` with byte 8'hA5 at edge k → `po_flag` high during cycle k+2 with `po_data=8'hA5`. `busy` low again 100 cycles later.
- **Simultaneous requests, no macro:** `req_flag=3'b111` in one cycle with bytes 11/22/33 → three pulses carrying 11, 22, 33 in that order, spaced 101 cycles apart, and no `req_ovf`.
- **Overflow:** requester 1 flags 8'h40 then 8'h41 while requester 0's frame is in WAIT → `req_ovf[1]` pulses once, and 8'h40 is sent next (8'h41 is lost).
- **Capture on grant:** requester 2 flags 8'h77 in the same cycle it is granted for 8'h66 → 8'h66 is sent now and 8'h77 one frame later, with no `req_ovf`.
- **Priority, macro defined:** `hv[1]` pending, then requester 0 flags 8'hEE during WAIT → 8'hEE is sent before requester 1's byte. Without the macro, requester 1's byte goes first.
- **Reset mid-WAIT:** assert `sys_rst` at cnt=50 with two bytes pending → all outputs return to reset values immediately, and no further `po_flag` occurs.
